// File: rtl/apb_reg_bank.sv
// APB4 completer with NUM_REGS read/write registers, byte strobes and a
// configurable number of wait states; out-of-range or misaligned accesses flag PSLVERR.
module apb_reg_bank #(
    parameter int unsigned             ADDR_WIDTH  = 8,
    parameter int unsigned             DATA_WIDTH  = 32,
    parameter int unsigned             NUM_REGS    = 4,
    parameter int unsigned             WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic                           PREADY,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned LSB   = $clog2(BYTES);
    localparam int unsigned IDX_W = ADDR_WIDTH - LSB;
    localparam logic [3:0]  WS4   = 4'(WAIT_STATES);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [3:0]            r_wcnt;

    logic [IDX_W-1:0]      w_idx;
    logic                  w_misalign;
    logic                  w_oob;
    logic                  w_err;
    logic                  w_acc;
    logic                  w_ready;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    assign w_idx = PADDR[ADDR_WIDTH-1:LSB];

    // Byte-wide buses have no sub-word address bits to check.
    generate
        if (LSB > 0) begin : g_align
            assign w_misalign = |PADDR[LSB-1:0];
        end else begin : g_noalign
            assign w_misalign = 1'b0;
        end
    endgenerate

    assign w_oob   = (32'(w_idx) >= NUM_REGS);
    assign w_err   = w_misalign || w_oob;
    assign w_acc   = PSEL && PENABLE;
    // Gated by PRESETn so the bus outputs read as idle while reset is held.
    assign w_ready = PRESETn && w_acc && (r_wcnt == WS4);
    assign w_wr_en = w_ready && PWRITE && !w_err;

    always_comb begin
        w_rd_mux = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_rd_mux = r_regs[i];
            end
        end
    end

    always_comb begin
        PREADY  = w_ready;
        PSLVERR = w_ready && w_err;
        PRDATA  = (w_ready && !PWRITE && !w_err) ? w_rd_mux : '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wcnt <= '0;
        end else if (w_acc && (r_wcnt != WS4)) begin
            r_wcnt <= r_wcnt + 4'd1;
        end else begin
            r_wcnt <= '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VALUE;
            end
        end else if (w_wr_en) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_idx == IDX_W'(i)) begin
                    for (int unsigned b = 0; b < BYTES; b++) begin
                        if (PSTRB[b]) begin
                            r_regs[i][8*b +: 8] <= PWDATA[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule
